// File: rtl/core_exu_div_pkg.sv
// Shared divider definitions: bus width, FSM encoding, counter width and
// the constant quotient returned for a zero divisor.
`ifndef DATA_BUS_WIDTH
`define DATA_BUS_WIDTH 32
`endif

package core_exu_div_pkg;

    localparam int DATA_BUS_WIDTH = `DATA_BUS_WIDTH;
    localparam int DIV_CNT_WIDTH  = 6;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_CALC = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

    // RISC-V defines x/0 as all ones for both signed and unsigned forms.
    localparam logic [DATA_BUS_WIDTH-1:0] DIV_ZERO_QUO = '1;

endpackage

// File: rtl/core_exu_div_step.sv
// One restoring-division iteration: shift {rem, quo} left, trial-subtract
// the divisor from the widened remainder and restore on borrow.
module core_exu_div_step
    import core_exu_div_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_BUS_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] rem_i,
    input  logic [DATA_WIDTH-1:0] quo_i,
    input  logic [DATA_WIDTH-1:0] divisor_i,
    output logic [DATA_WIDTH-1:0] rem_o,
    output logic [DATA_WIDTH-1:0] quo_o
);

    logic [DATA_WIDTH:0] rem_sh;
    logic [DATA_WIDTH:0] diff;

    // Extra bit on the shifted remainder keeps the borrow visible.
    always_comb begin
        rem_sh = {rem_i, quo_i[DATA_WIDTH-1]};
        diff   = rem_sh - {1'b0, divisor_i};
        if (!diff[DATA_WIDTH]) begin
            rem_o = diff[DATA_WIDTH-1:0];
            quo_o = {quo_i[DATA_WIDTH-2:0], 1'b1};
        end else begin
            rem_o = rem_sh[DATA_WIDTH-1:0];
            quo_o = {quo_i[DATA_WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/core_exu_div.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU. Operands are
// made unsigned on accept, one quotient bit is produced per cycle, and the
// signs are reapplied when results are registered on DONE entry.
`ifndef DATA_BUS_WIDTH
`define DATA_BUS_WIDTH 32
`endif

module core_exu_div
    import core_exu_div_pkg::*;
#(
    parameter int DATA_WIDTH = `DATA_BUS_WIDTH,
    parameter int CNT_WIDTH  = DIV_CNT_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  start_i,
    input  logic                  sign_i,
    input  logic [DATA_WIDTH-1:0] dividend_i,
    input  logic [DATA_WIDTH-1:0] divisor_i,
    input  logic                  flush_i,
    output logic                  busy_o,
    output logic                  valid_o,
    output logic [DATA_WIDTH-1:0] quotient_o,
    output logic [DATA_WIDTH-1:0] remainder_o
);

    localparam logic [DATA_WIDTH-1:0] MIN_NEG  = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [CNT_WIDTH-1:0]  LAST_CNT = CNT_WIDTH'(DATA_WIDTH-1);

    div_state_e            state_q, state_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, dvsr_q, dvsr_d;
    logic [DATA_WIDTH-1:0] quotient_q, quotient_d, remainder_q, remainder_d;
    logic                  neg_q_q, neg_q_d, neg_r_q, neg_r_d;

    logic [DATA_WIDTH-1:0] step_rem, step_quo, dvd_abs, dvs_abs;
    logic                  dvd_neg, dvs_neg, div_zero, sgn_ovf;

    core_exu_div_step #(.DATA_WIDTH(DATA_WIDTH)) u_step (
        .rem_i     (rem_q),
        .quo_i     (quo_q),
        .divisor_i (dvsr_q),
        .rem_o     (step_rem),
        .quo_o     (step_quo)
    );

    // Classify the incoming operands; only used in the accept cycle.
    always_comb begin
        dvd_neg  = sign_i & dividend_i[DATA_WIDTH-1];
        dvs_neg  = sign_i & divisor_i[DATA_WIDTH-1];
        dvd_abs  = dvd_neg ? -dividend_i : dividend_i;
        dvs_abs  = dvs_neg ? -divisor_i  : divisor_i;
        div_zero = (divisor_i == '0);
        sgn_ovf  = sign_i && (dividend_i == MIN_NEG) && (divisor_i == '1);
    end

    // Next-state, datapath and result-register update.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvsr_d      = dvsr_q;
        neg_q_d     = neg_q_q;
        neg_r_d     = neg_r_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        case (state_q)
            DIV_IDLE: begin
                if (start_i) begin
                    neg_q_d = sign_i & (dividend_i[DATA_WIDTH-1] ^ divisor_i[DATA_WIDTH-1]);
                    neg_r_d = dvd_neg;
                    cnt_d   = '0;
                    if (div_zero) begin
                        // Remainder is the raw dividend, not its magnitude.
                        quotient_d  = DATA_WIDTH'(DIV_ZERO_QUO);
                        remainder_d = dividend_i;
                        state_d     = DIV_DONE;
                    end else if (sgn_ovf) begin
                        quotient_d  = MIN_NEG;
                        remainder_d = '0;
                        state_d     = DIV_DONE;
                    end else begin
                        rem_d   = '0;
                        quo_d   = dvd_abs;
                        dvsr_d  = dvs_abs;
                        state_d = DIV_CALC;
                    end
                end
            end
            DIV_CALC: begin
                rem_d = step_rem;
                quo_d = step_quo;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_CNT) begin
                    quotient_d  = neg_q_q ? -step_quo : step_quo;
                    remainder_d = neg_r_q ? -step_rem : step_rem;
                    state_d     = DIV_DONE;
                end
            end
            DIV_DONE: state_d = DIV_IDLE;
            default:  state_d = DIV_IDLE;
        endcase
        // Flush wins over everything, including a start seen in IDLE.
        if (flush_i) begin
            state_d     = DIV_IDLE;
            cnt_d       = '0;
            quotient_d  = quotient_q;
            remainder_d = remainder_q;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= DIV_IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dvsr_q      <= '0;
            neg_q_q     <= 1'b0;
            neg_r_q     <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dvsr_q      <= dvsr_d;
            neg_q_q     <= neg_q_d;
            neg_r_q     <= neg_r_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
        end
    end

    assign busy_o      = (state_q != DIV_IDLE);
    assign valid_o     = (state_q == DIV_DONE) && !flush_i;
    assign quotient_o  = quotient_q;
    assign remainder_o = remainder_q;

endmodule

// File: tb/tb_core_exu_div.sv
// Bench for core_exu_div: directed vector table, hand-written flush/reset/
// busy-start sequences, and random operations against an arithmetic model.
module tb_core_exu_div;

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic        start_i = 1'b0;
    logic        sign_i = 1'b0;
    logic [31:0] dividend_i = '0;
    logic [31:0] divisor_i = '0;
    logic        flush_i = 1'b0;
    logic        busy_o, valid_o;
    logic [31:0] quotient_o, remainder_o;

    int n_pass = 0;
    int n_total = 0;

    core_exu_div dut (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .start_i     (start_i),
        .sign_i      (sign_i),
        .dividend_i  (dividend_i),
        .divisor_i   (divisor_i),
        .flush_i     (flush_i),
        .busy_o      (busy_o),
        .valid_o     (valid_o),
        .quotient_o  (quotient_o),
        .remainder_o (remainder_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        s;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        int          lat;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
        else n_pass++;
    endtask

    // Reference: RISC-V division semantics from plain integer arithmetic.
    function automatic void model(input logic s, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r, output int lat);
        longint sa, sb;
        if (b == 0) begin
            q = 32'hFFFF_FFFF; r = a; lat = 1;
        end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000; r = 0; lat = 1;
        end else if (s) begin
            sa = $signed(a); sb = $signed(b);
            q = 32'(sa / sb); r = 32'(sa % sb); lat = 33;
        end else begin
            q = a / b; r = a % b; lat = 33;
        end
    endfunction

    // Called at a negedge with the DUT idle; returns at a negedge one cycle
    // after valid_o. poke>0 pulses a second start during the operation.
    task automatic run_op(input logic s, input logic [31:0] a, input logic [31:0] b, input int poke,
                          output logic [31:0] q, output logic [31:0] r,
                          output int lat, output int bcnt, output logic one_pulse);
        int n;
        sign_i = s; dividend_i = a; divisor_i = b; start_i = 1'b1;
        @(posedge clk_i); #1 start_i = 1'b0;
        n = 0; bcnt = 0;
        forever begin
            @(negedge clk_i);
            n++;
            start_i = 1'b0;
            if (busy_o) bcnt++;
            if (valid_o) break;
            if (n == poke) begin
                start_i = 1'b1; dividend_i = 32'd56; divisor_i = 32'd7; sign_i = 1'b0;
            end
            if (n > 100) begin
                $display("FAIL timeout: no valid_o after %0d cycles, expected within 33", n);
                break;
            end
        end
        lat = n; q = quotient_o; r = remainder_o;
        @(negedge clk_i);
        one_pulse = !valid_o;
    endtask

    task automatic count_valid(input int cycles, output int nv);
        nv = 0;
        repeat (cycles) begin
            @(negedge clk_i);
            if (valid_o) nv++;
        end
    endtask

    vec_t        vt[11];
    logic [31:0] q, r, eq, er;
    int          lat, elat, bcnt, nv;
    logic        op1;

    initial begin
        vt[0]  = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          33};
        vt[1]  = '{1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  33};
        vt[2]  = '{1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          33};
        vt[3]  = '{1'b1, 32'h1234_5678,  32'd0,          32'hFFFF_FFFF,  32'h1234_5678,  1};
        vt[4]  = '{1'b0, 32'h1234_5678,  32'd0,          32'hFFFF_FFFF,  32'h1234_5678,  1};
        vt[5]  = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1};
        vt[6]  = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000,  33};
        vt[7]  = '{1'b1, 32'hFFFF_FFF9,  32'hFFFF_FFFE,  32'd3,          32'hFFFF_FFFF,  33};
        vt[8]  = '{1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          33};
        vt[9]  = '{1'b1, 32'h8000_0000,  32'd1,          32'h8000_0000,  32'd0,          33};
        vt[10] = '{1'b0, 32'd5,          32'd9,          32'd0,          32'd5,          33};

        // Reset state
        #12;
        chk("rst_busy", busy_o, 0);
        chk("rst_valid", valid_o, 0);
        chk("rst_quo", quotient_o, 0);
        chk("rst_rem", remainder_o, 0);
        @(negedge clk_i); rst_n_i = 1'b1;
        @(negedge clk_i);

        // Directed table (consecutive entries are back-to-back)
        for (int i = 0; i < 11; i++) begin
            run_op(vt[i].s, vt[i].a, vt[i].b, 0, q, r, lat, bcnt, op1);
            chk($sformatf("vec%0d_quo", i), q, vt[i].q);
            chk($sformatf("vec%0d_rem", i), r, vt[i].r);
            chk($sformatf("vec%0d_lat", i), lat, vt[i].lat);
            chk($sformatf("vec%0d_busy", i), bcnt, vt[i].lat);
            chk($sformatf("vec%0d_pulse", i), op1, 1);
        end

        // Start during CALC is ignored
        run_op(1'b0, 32'd100, 32'd7, 5, q, r, lat, bcnt, op1);
        chk("busy_start_quo", q, 14);
        chk("busy_start_rem", r, 2);
        chk("busy_start_lat", lat, 33);

        // Flush at cycle 10 of DIVU 1000/3
        sign_i = 1'b0; dividend_i = 32'd1000; divisor_i = 32'd3; start_i = 1'b1;
        @(posedge clk_i); #1 start_i = 1'b0;
        repeat (10) @(negedge clk_i);
        flush_i = 1'b1;
        @(posedge clk_i); #1 flush_i = 1'b0;
        chk("flush_busy", busy_o, 0);
        count_valid(40, nv);
        chk("flush_no_valid", nv, 0);
        chk("flush_hold_quo", quotient_o, 14);
        chk("flush_hold_rem", remainder_o, 2);
        run_op(1'b0, 32'd1000, 32'd3, 0, q, r, lat, bcnt, op1);
        chk("post_flush_quo", q, 333);
        chk("post_flush_rem", r, 1);
        chk("post_flush_lat", lat, 33);

        // Flush beats start in IDLE
        sign_i = 1'b0; dividend_i = 32'd9; divisor_i = 32'd0; start_i = 1'b1; flush_i = 1'b1;
        @(posedge clk_i); #1 start_i = 1'b0; flush_i = 1'b0;
        chk("flush_idle_busy", busy_o, 0);
        count_valid(3, nv);
        chk("flush_idle_no_valid", nv, 0);
        chk("flush_idle_quo", quotient_o, 333);

        // Flush masks valid_o in the DONE cycle
        sign_i = 1'b0; dividend_i = 32'd9; divisor_i = 32'd0; start_i = 1'b1;
        @(posedge clk_i); #1 start_i = 1'b0;
        @(negedge clk_i); flush_i = 1'b1; #1;
        chk("flush_done_valid", valid_o, 0);
        @(posedge clk_i); #1 flush_i = 1'b0;
        chk("flush_done_busy", busy_o, 0);
        @(negedge clk_i);

        // Reset at cycle 15 of an operation
        sign_i = 1'b0; dividend_i = 32'd12345; divisor_i = 32'd5; start_i = 1'b1;
        @(posedge clk_i); #1 start_i = 1'b0;
        repeat (15) @(negedge clk_i);
        rst_n_i = 1'b0; #1;
        chk("midrst_busy", busy_o, 0);
        chk("midrst_valid", valid_o, 0);
        chk("midrst_quo", quotient_o, 0);
        chk("midrst_rem", remainder_o, 0);
        @(negedge clk_i); rst_n_i = 1'b1;
        count_valid(40, nv);
        chk("midrst_no_valid", nv, 0);

        // Random operations against the model
        for (int i = 0; i < 150; i++) begin
            logic        s;
            logic [31:0] a, b;
            s = 1'($urandom_range(0, 1));
            a = $urandom;
            case ($urandom_range(0, 6))
                0: b = 32'd0;
                1: b = $urandom_range(1, 15);
                2: b = 32'hFFFF_FFFF;
                3: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                4: begin a = $urandom_range(0, 1000); b = $urandom; end
                default: b = $urandom;
            endcase
            model(s, a, b, eq, er, elat);
            run_op(s, a, b, 0, q, r, lat, bcnt, op1);
            chk($sformatf("rnd%0d_quo s=%0d %h/%h", i, s, a, b), q, eq);
            chk($sformatf("rnd%0d_rem s=%0d %h/%h", i, s, a, b), r, er);
            chk($sformatf("rnd%0d_lat", i), lat, elat);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
